// File: rtl/cpu86_mem_arbiter.sv
// cpu86_mem_arbiter: shares the cpu86 memory port between two requesters.
// Round-robin grant into a single registered request stage, plus an in-order
// ID FIFO that steers each read response back to the port that issued it.
//
// Handshake: a request word moves on any cycle where tvalid & tready are both
// high at the rising clock edge. tvalid never waits for tready, and tready may
// depend on tvalid. The response channels have no ready: a response pulse
// must be taken on the cycle it appears.
module cpu86_mem_arbiter #(
    parameter int MAX_OUTSTANDING = 8,
    parameter int WE_BIT          = 63
) (
    input  logic                               clk,
    input  logic                               resetn,
    input  logic                               s0_axis_req_tvalid,
    output logic                               s0_axis_req_tready,
    input  logic [63:0]                        s0_axis_req_tdata,
    output logic                               s0_axis_res_tvalid,
    output logic [31:0]                        s0_axis_res_tdata,
    input  logic                               s1_axis_req_tvalid,
    output logic                               s1_axis_req_tready,
    input  logic [63:0]                        s1_axis_req_tdata,
    output logic                               s1_axis_res_tvalid,
    output logic [31:0]                        s1_axis_res_tdata,
    output logic                               m_axis_req_tvalid,
    input  logic                               m_axis_req_tready,
    output logic [63:0]                        m_axis_req_tdata,
    input  logic                               s_axis_res_tvalid,
    input  logic [31:0]                        s_axis_res_tdata,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
    output logic                               err_unexpected_res
);

    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(MAX_OUTSTANDING);

    // Output stage, round-robin pointer (1 = port 1 preferred), ID FIFO
    logic                       out_valid_q;
    logic [63:0]                out_data_q;
    logic                       rr_q;
    logic [MAX_OUTSTANDING-1:0] id_mem_q;
    logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic                       res0_valid_q, res1_valid_q;
    logic [31:0]                res0_data_q, res1_data_q;
    logic                       err_q;

    logic        slot_free, fifo_full, fifo_empty;
    logic        elig0, elig1, grant0, grant1;
    logic        accept, acc_port, push, pop, head_id;
    logic [63:0] acc_data;

    // Arbitration: pick an eligible port, round-robin when both compete
    always_comb begin
        slot_free  = !out_valid_q || m_axis_req_tready;
        fifo_full  = (cnt_q == FULL_CNT);
        fifo_empty = (cnt_q == '0);
        // Writes need no FIFO slot, so they keep flowing while reads are blocked
        elig0 = s0_axis_req_tvalid && (s0_axis_req_tdata[WE_BIT] || !fifo_full);
        elig1 = s1_axis_req_tvalid && (s1_axis_req_tdata[WE_BIT] || !fifo_full);
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (elig0 && elig1) begin
            grant0 = !rr_q;
            grant1 = rr_q;
        end else begin
            grant0 = elig0;
            grant1 = elig1;
        end
        // Ready is held low while reset is asserted
        s0_axis_req_tready = resetn && slot_free && grant0;
        s1_axis_req_tready = resetn && slot_free && grant1;
        accept   = s0_axis_req_tready || s1_axis_req_tready;
        acc_port = s1_axis_req_tready;
        acc_data = acc_port ? s1_axis_req_tdata : s0_axis_req_tdata;
        push     = accept && !acc_data[WE_BIT];
        pop      = s_axis_res_tvalid && !fifo_empty;
        head_id  = id_mem_q[rd_ptr_q];
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d    = cnt_q + CW'(push) - CW'(pop);
    end

    // Registered request stage toward memory; data only changes on accept
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= acc_data;
        end else if (m_axis_req_tready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Round-robin pointer moves to the other port only when a request is taken
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_q <= 1'b0;
        end else if (accept) begin
            rr_q <= !acc_port;
        end
    end

    // ID FIFO: records the issuing port of each read in accept order
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            id_mem_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                id_mem_q[wr_ptr_q] <= acc_port;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Response steering: one-cycle pulse to the head-of-FIFO port, data held
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            res0_valid_q <= 1'b0;
            res1_valid_q <= 1'b0;
            res0_data_q  <= '0;
            res1_data_q  <= '0;
        end else begin
            res0_valid_q <= pop && !head_id;
            res1_valid_q <= pop && head_id;
            if (pop && !head_id) begin
                res0_data_q <= s_axis_res_tdata;
            end
            if (pop && head_id) begin
                res1_data_q <= s_axis_res_tdata;
            end
        end
    end

    // Sticky flag for a response that no recorded read accounts for
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_q <= 1'b0;
        end else if (s_axis_res_tvalid && fifo_empty) begin
            err_q <= 1'b1;
        end
    end

    assign m_axis_req_tvalid  = out_valid_q;
    assign m_axis_req_tdata   = out_data_q;
    assign s0_axis_res_tvalid = res0_valid_q;
    assign s0_axis_res_tdata  = res0_data_q;
    assign s1_axis_res_tvalid = res1_valid_q;
    assign s1_axis_res_tdata  = res1_data_q;
    assign outstanding        = cnt_q;
    assign err_unexpected_res = err_q;

endmodule

// File: tb/tb_cpu86_mem_arbiter.sv
// Bench for cpu86_mem_arbiter: table of per-cycle vectors plus hand-written
// sequences for FIFO-full, push/pop collision and reset mid-flight.
module tb_cpu86_mem_arbiter;

    logic        clk;
    logic        resetn;
    logic        s0_req_v, s0_req_r, s0_res_v;
    logic [63:0] s0_req_d;
    logic [31:0] s0_res_d;
    logic        s1_req_v, s1_req_r, s1_res_v;
    logic [63:0] s1_req_d;
    logic [31:0] s1_res_d;
    logic        m_v, m_r;
    logic [63:0] m_d;
    logic        r_v;
    logic [31:0] r_d;
    logic [3:0]  outst;
    logic        err;

    int checks   = 0;
    int failures = 0;

    cpu86_mem_arbiter #(.MAX_OUTSTANDING(8), .WE_BIT(63)) dut (
        .clk                (clk),
        .resetn             (resetn),
        .s0_axis_req_tvalid (s0_req_v),
        .s0_axis_req_tready (s0_req_r),
        .s0_axis_req_tdata  (s0_req_d),
        .s0_axis_res_tvalid (s0_res_v),
        .s0_axis_res_tdata  (s0_res_d),
        .s1_axis_req_tvalid (s1_req_v),
        .s1_axis_req_tready (s1_req_r),
        .s1_axis_req_tdata  (s1_req_d),
        .s1_axis_res_tvalid (s1_res_v),
        .s1_axis_res_tdata  (s1_res_d),
        .m_axis_req_tvalid  (m_v),
        .m_axis_req_tready  (m_r),
        .m_axis_req_tdata   (m_d),
        .s_axis_res_tvalid  (r_v),
        .s_axis_res_tdata   (r_d),
        .outstanding        (outst),
        .err_unexpected_res (err)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        s0v;
        logic [63:0] s0d;
        logic        s1v;
        logic [63:0] s1d;
        logic        mrdy;
        logic        rv;
        logic [31:0] rd;
        logic        e_s0r;
        logic        e_s1r;
        logic        e_mv;
        logic [63:0] e_md;
        logic        e_r0v;
        logic [31:0] e_r0d;
        logic        e_r1v;
        logic [31:0] e_r1d;
        logic [3:0]  e_out;
        logic        e_err;
    } vec_t;

    vec_t tbl[$];

    localparam logic [63:0] R0 = 64'h0000_0000_0001_0000;
    localparam logic [63:0] B0 = 64'h0000_0000_0000_0B00;
    localparam logic [63:0] B1 = 64'h0000_0000_0000_1B00;
    localparam logic [63:0] C0 = 64'h0000_0000_0000_0C00;
    localparam logic [63:0] C1 = 64'h0000_0000_0000_1C00;
    localparam logic [63:0] W0 = 64'h8000_0000_0000_0F00;
    localparam logic [31:0] CB = 32'hCAFE_BABE;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp_v);
        end
    endtask

    task automatic drive(input logic s0v, input logic [63:0] s0d, input logic s1v,
                         input logic [63:0] s1d, input logic mrdy, input logic rv,
                         input logic [31:0] rd);
        s0_req_v = s0v;
        s0_req_d = s0d;
        s1_req_v = s1v;
        s1_req_d = s1d;
        m_r      = mrdy;
        r_v      = rv;
        r_d      = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(0, 64'h0, 0, 64'h0, 1, 0, 32'h0);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
    endtask

    initial begin
        // Reset with requests pending: ready must stay low
        resetn = 1'b0;
        drive(1, R0, 1, B1, 1, 0, 32'h0);
        tick();
        chk("rst_s0_tready", 64'(s0_req_r), 64'h0);
        chk("rst_s1_tready", 64'(s1_req_r), 64'h0);
        chk("rst_m_tvalid",  64'(m_v), 64'h0);
        chk("rst_m_tdata",   m_d, 64'h0);
        chk("rst_s0_res_v",  64'(s0_res_v), 64'h0);
        chk("rst_s0_res_d",  64'(s0_res_d), 64'h0);
        chk("rst_s1_res_v",  64'(s1_res_v), 64'h0);
        chk("rst_s1_res_d",  64'(s1_res_d), 64'h0);
        chk("rst_outst",     64'(outst), 64'h0);
        chk("rst_err",       64'(err), 64'h0);
        drive(0, 64'h0, 0, 64'h0, 1, 0, 32'h0);
        resetn = 1'b1;

        // Single read, round-robin alternation, back-pressure hold
        tbl.push_back(vec_t'{0,1,R0,0,0,1,0,0,     1,0, 1,R0, 0,0,  0,0,  1,0});
        tbl.push_back(vec_t'{0,0,0,0,0,1,0,0,      0,0, 0,R0, 0,0,  0,0,  1,0});
        tbl.push_back(vec_t'{0,0,0,0,0,1,1,CB,     0,0, 0,R0, 1,CB, 0,0,  0,0});
        tbl.push_back(vec_t'{0,0,0,0,0,1,0,0,      0,0, 0,R0, 0,CB, 0,0,  0,0});
        tbl.push_back(vec_t'{1,1,B0,1,B1,1,0,0,    1,0, 1,B0, 0,0,  0,0,  1,0});
        tbl.push_back(vec_t'{0,1,B0,1,B1,1,0,0,    0,1, 1,B1, 0,0,  0,0,  2,0});
        tbl.push_back(vec_t'{0,1,B0,1,B1,1,0,0,    1,0, 1,B0, 0,0,  0,0,  3,0});
        tbl.push_back(vec_t'{0,1,B0,1,B1,1,0,0,    0,1, 1,B1, 0,0,  0,0,  4,0});
        tbl.push_back(vec_t'{0,0,0,0,0,1,1,'hA0,   0,0, 0,B1, 1,'hA0, 0,0,     3,0});
        tbl.push_back(vec_t'{0,0,0,0,0,1,1,'hA1,   0,0, 0,B1, 0,'hA0, 1,'hA1,  2,0});
        tbl.push_back(vec_t'{0,0,0,0,0,1,1,'hA2,   0,0, 0,B1, 1,'hA2, 0,'hA1,  1,0});
        tbl.push_back(vec_t'{0,0,0,0,0,1,1,'hA3,   0,0, 0,B1, 0,'hA2, 1,'hA3,  0,0});
        tbl.push_back(vec_t'{0,1,C0,1,C1,0,0,0,    1,0, 1,C0, 0,'hA2, 0,'hA3,  1,0});
        for (int k = 0; k < 5; k++) begin
            tbl.push_back(vec_t'{0,1,C0,1,C1,0,0,0, 0,0, 1,C0, 0,'hA2, 0,'hA3, 1,0});
        end
        tbl.push_back(vec_t'{0,1,C0,1,C1,1,0,0,    0,1, 1,C1, 0,'hA2, 0,'hA3,  2,0});
        tbl.push_back(vec_t'{0,0,0,0,0,1,0,0,      0,0, 0,C1, 0,'hA2, 0,'hA3,  2,0});

        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            drive(tbl[i].s0v, tbl[i].s0d, tbl[i].s1v, tbl[i].s1d,
                  tbl[i].mrdy, tbl[i].rv, tbl[i].rd);
            #1;
            chk($sformatf("row%0d_s0_tready", i), 64'(s0_req_r), 64'(tbl[i].e_s0r));
            chk($sformatf("row%0d_s1_tready", i), 64'(s1_req_r), 64'(tbl[i].e_s1r));
            tick();
            chk($sformatf("row%0d_m_tvalid", i), 64'(m_v), 64'(tbl[i].e_mv));
            chk($sformatf("row%0d_m_tdata", i),  m_d, tbl[i].e_md);
            chk($sformatf("row%0d_s0_res_v", i), 64'(s0_res_v), 64'(tbl[i].e_r0v));
            chk($sformatf("row%0d_s0_res_d", i), 64'(s0_res_d), 64'(tbl[i].e_r0d));
            chk($sformatf("row%0d_s1_res_v", i), 64'(s1_res_v), 64'(tbl[i].e_r1v));
            chk($sformatf("row%0d_s1_res_d", i), 64'(s1_res_d), 64'(tbl[i].e_r1d));
            chk($sformatf("row%0d_outst", i),    64'(outst), 64'(tbl[i].e_out));
            chk($sformatf("row%0d_err", i),      64'(err), 64'(tbl[i].e_err));
        end

        // FIFO full: port 1 reads blocked, port 0 write passes
        do_reset();
        for (int k = 0; k < 8; k++) begin
            drive(0, 64'h0, 1, 64'h1D00 + 64'(k), 1, 0, 32'h0);
            #1;
            chk("full_fill_s1_tready", 64'(s1_req_r), 64'h1);
            tick();
        end
        chk("full_outst8", 64'(outst), 64'h8);
        drive(1, W0, 1, 64'h1E00, 1, 0, 32'h0);
        #1;
        chk("full_write_s0_tready", 64'(s0_req_r), 64'h1);
        chk("full_read_s1_tready",  64'(s1_req_r), 64'h0);
        tick();
        chk("full_write_m_tdata", m_d, W0);
        chk("full_write_outst",   64'(outst), 64'h8);
        drive(0, 64'h0, 1, 64'h1E00, 1, 1, 32'h44);
        #1;
        chk("full_pop_blocks_s1", 64'(s1_req_r), 64'h0);
        tick();
        chk("full_pop_outst",  64'(outst), 64'h7);
        chk("full_pop_s1_res_v", 64'(s1_res_v), 64'h1);
        chk("full_pop_s1_res_d", 64'(s1_res_d), 64'h44);
        drive(0, 64'h0, 1, 64'h1E00, 1, 0, 32'h0);
        #1;
        chk("full_after_s1_tready", 64'(s1_req_r), 64'h1);
        tick();
        chk("full_after_outst", 64'(outst), 64'h8);
        chk("full_after_m_tdata", m_d, 64'h1E00);

        // Push and pop on the same edge with three reads in flight
        do_reset();
        drive(1, 64'h0E00, 0, 64'h0, 1, 0, 32'h0); tick();
        drive(0, 64'h0, 1, 64'h1E01, 1, 0, 32'h0); tick();
        drive(1, 64'h0E02, 0, 64'h0, 1, 0, 32'h0); tick();
        chk("col_outst3", 64'(outst), 64'h3);
        drive(0, 64'h0, 1, 64'h1E03, 1, 1, 32'h55);
        #1;
        chk("col_s1_tready", 64'(s1_req_r), 64'h1);
        tick();
        chk("col_outst_same", 64'(outst), 64'h3);
        chk("col_s0_res_v", 64'(s0_res_v), 64'h1);
        chk("col_s0_res_d", 64'(s0_res_d), 64'h55);
        chk("col_s1_res_v", 64'(s1_res_v), 64'h0);
        drive(0, 64'h0, 0, 64'h0, 1, 1, 32'h56);
        tick();
        chk("col_next_s1_res_v", 64'(s1_res_v), 64'h1);
        chk("col_next_s1_res_d", 64'(s1_res_d), 64'h56);
        chk("col_next_s0_res_v", 64'(s0_res_v), 64'h0);
        chk("col_next_outst", 64'(outst), 64'h2);

        // Reset with reads in flight, then a stale response
        do_reset();
        drive(1, 64'h0D00, 0, 64'h0, 1, 0, 32'h0); tick();
        drive(0, 64'h0, 1, 64'h1D00, 1, 0, 32'h0); tick();
        chk("mid_outst2", 64'(outst), 64'h2);
        drive(1, 64'h0D01, 0, 64'h0, 1, 0, 32'h0);
        resetn = 1'b0;
        #1;
        chk("mid_async_outst",  64'(outst), 64'h0);
        chk("mid_async_m_v",    64'(m_v), 64'h0);
        chk("mid_async_tready", 64'(s0_req_r), 64'h0);
        tick();
        resetn = 1'b1;
        drive(0, 64'h0, 0, 64'h0, 1, 1, 32'h66);
        tick();
        chk("stale_s0_res_v", 64'(s0_res_v), 64'h0);
        chk("stale_s1_res_v", 64'(s1_res_v), 64'h0);
        chk("stale_err",      64'(err), 64'h1);
        chk("stale_outst",    64'(outst), 64'h0);
        drive(0, 64'h0, 0, 64'h0, 1, 0, 32'h0);
        tick();
        chk("stale_err_sticky", 64'(err), 64'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
